brush_draw_engine: RTL
======================

// Module: brush_draw_engine
// PURPOSE
//  Parametrised successor to the single-pixel draw engine. Sits between the command decoder and the
//  framebuffer writer. Tracks the draw cursor, palette cursor and selected colour, as before. ENTER in
//  DRAW mode now stamps a clipped square brush (1..MAX_BRUSH px) as a stream of pixel writes.
//  Both command input and write output use valid/ready handshakes.
// PARAMETERS
//  CANVAS_W  64  canvas width in pixels
//  CANVAS_H  64  canvas height in pixels
//  COORD_W   7   width of x/y coordinates; must satisfy 2**COORD_W > max(CANVAS_W,CANVAS_H)
//  PAL_COLS  16  palette grid columns
//  PAL_ROWS  16  palette grid rows
//  COLOR_W   8   colour index width; must satisfy 2**COLOR_W >= PAL_COLS*PAL_ROWS
//  MAX_BRUSH 4   largest brush edge in pixels (>=1)
//  WRAP      0   0: draw cursor clamps at edges; 1: draw cursor wraps (palette cursor always clamps)
// PORTS
//  clk            in   1        clock, rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  cmd_valid      in   1        command present
//  cmd_ready      out  1        engine accepts a command; a command is taken when cmd_valid && cmd_ready
//  cmd_id         in   4        0 NONE,1 UP,2 DOWN,3 LEFT,4 RIGHT,5 ENTER,6 COLOR,7 PAL_MOVE,8 PAL_SEL,
//                               9 RETURN_DRAW,10 BRUSH_INC,11 BRUSH_DEC; 12-15 are no-ops
//  x_in, y_in     in   COORD_W  palette target for PAL_MOVE
//  mode           out  1        0 DRAW, 1 PALETTE
//  cursor_x/y     out  COORD_W  draw cursor
//  p_px/p_py      out  clog2(PAL_COLS)/clog2(PAL_ROWS)  palette cursor
//  brush_size     out  clog2(MAX_BRUSH+1)  current brush edge, 1..MAX_BRUSH
//  busy           out  1        stamp in progress (= !cmd_ready)
//  wr_valid       out  1        pixel write pending
//  wr_ready       in   1        framebuffer accepts the write
//  wr_x/wr_y      out  COORD_W  pixel coordinate
//  wr_color       out  COLOR_W  pixel colour
//  selected_color out  COLOR_W  p_py*PAL_COLS+p_px, latched on selection
// BEHAVIOUR
//  Reset state:
//  - all outputs 0, except brush_size=1 and cmd_ready=1
//  - FSM in IDLE; saved cursor = (0,0)
//  FSM:
//  - IDLE: cmd_ready=1; accepted commands execute in one cycle; results are visible on the next edge.
//  - STAMP: cmd_ready=0; cmd_id is ignored.
//  Movement:
//  - UP/DOWN/LEFT/RIGHT move the draw cursor (mode 0) or the palette cursor (mode 1) by 1.
//  - Draw cursor clamps at 0 and CANVAS_W-1 / CANVAS_H-1, or wraps when WRAP=1 (0-1 -> W-1, W-1+1 -> 0).
//  - Palette cursor clamps at 0 and PAL_COLS-1 / PAL_ROWS-1.
//  Mode changes:
//  - COLOR in mode 0: save cursor, mode<=1, p_px=p_py=0. In mode 1 it is a no-op and saved is not overwritten.
//  - PAL_MOVE in mode 1: p_px<=min(x_in,PAL_COLS-1), p_py<=min(y_in,PAL_ROWS-1). No-op in mode 0.
//  - PAL_SEL or ENTER in mode 1: selected_color<=p_py*PAL_COLS+p_px, mode<=0, cursor<=saved.
//  - RETURN_DRAW in mode 1: mode<=0, cursor<=saved, colour unchanged. No-op in mode 0.
//  Brush:
//  - BRUSH_INC saturates at MAX_BRUSH; BRUSH_DEC saturates at 1. Valid in either mode.
//  Stamp (ENTER in mode 0):
//  - Latch ox=cursor_x, oy=cursor_y, colour=selected_color.
//  - Effective size: ew=min(brush,CANVAS_W-ox), eh=min(brush,CANVAS_H-oy). Clipped at right/bottom only.
//  - Go to STAMP. Next cycle wr_valid=1 with (ox,oy).
//  - Scan order is row-major: dx 0..ew-1 inner, dy 0..eh-1 outer.
//  - On wr_valid&&wr_ready the next pixel is presented the following cycle, for 1 pixel/cycle at full
//    throughput.
//  - While wr_ready=0, wr_valid/wr_x/wr_y/wr_color hold stable.
//  - On the handshake of the last pixel: wr_valid<=0, FSM to IDLE, cmd_ready=1 the next cycle.
//  - Exactly ew*eh writes are issued; there are no gaps when wr_ready stays high.
//  - Cursor, brush and mode do not change during a stamp.
//  Reset mid-stamp:
//  - Aborts immediately: wr_valid=0 asynchronously, remaining pixels are dropped.
// TESTING
//  1. brush=1, cursor (5,7), selected 0x23, ENTER, wr_ready=1 -> one write (5,7,0x23); cmd_ready low for exactly 1 cycle.
//  2. BRUSH_INC x2 (brush=3), cursor (62,10), ENTER -> 6 writes (62,10)(63,10)(62,11)(63,11)(62,12)(63,12) on consecutive cycles.
//  3. Same as 2 with wr_ready low for 3 cycles at pixel 2 -> (63,10) held stable 4 cycles; order unchanged; cmd_valid pulses meanwhile are not accepted.
//  4. COLOR at cursor (20,30), RIGHT x3, DOWN x2, PAL_SEL -> selected_color=0x23, mode=0, cursor (20,30); PAL_MOVE x_in=40 y_in=1 (mode 1) -> p_px=15, p_py=1.
//  5. WRAP=1: LEFT at x=0 -> x=63. WRAP=0: LEFT at x=0 -> x stays 0. BRUSH_INC x5 -> 4; BRUSH_DEC x6 -> 1.
//  6. Assert reset_n=0 during pixel 3 of a 4x4 stamp -> wr_valid=0 without waiting for clk; after release all outputs at reset values, brush_size=1, cmd_ready=1.

Source files
------------

// File: rtl/brush_draw_engine.sv
// Draw-cursor / palette-cursor engine that stamps a clipped square brush as a
// stream of valid/ready pixel writes toward the framebuffer writer.
module brush_draw_engine #(
  parameter int unsigned CANVAS_W  = 64,
  parameter int unsigned CANVAS_H  = 64,
  parameter int unsigned COORD_W   = 7,
  parameter int unsigned PAL_COLS  = 16,
  parameter int unsigned PAL_ROWS  = 16,
  parameter int unsigned COLOR_W   = 8,
  parameter int unsigned MAX_BRUSH = 4,
  parameter int unsigned WRAP      = 0,
  localparam int unsigned PX_W = (PAL_COLS > 1) ? $clog2(PAL_COLS) : 1,
  localparam int unsigned PY_W = (PAL_ROWS > 1) ? $clog2(PAL_ROWS) : 1,
  localparam int unsigned BR_W = $clog2(MAX_BRUSH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_id,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic               mode,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic [PX_W-1:0]    p_px,
  output logic [PY_W-1:0]    p_py,
  output logic [BR_W-1:0]    brush_size,
  output logic               busy,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [COORD_W-1:0] wr_x,
  output logic [COORD_W-1:0] wr_y,
  output logic [COLOR_W-1:0] wr_color,
  output logic [COLOR_W-1:0] selected_color
);

  localparam logic [3:0] CmdUp      = 4'd1;
  localparam logic [3:0] CmdDown    = 4'd2;
  localparam logic [3:0] CmdLeft    = 4'd3;
  localparam logic [3:0] CmdRight   = 4'd4;
  localparam logic [3:0] CmdEnter   = 4'd5;
  localparam logic [3:0] CmdColor   = 4'd6;
  localparam logic [3:0] CmdPalMove = 4'd7;
  localparam logic [3:0] CmdPalSel  = 4'd8;
  localparam logic [3:0] CmdReturn  = 4'd9;
  localparam logic [3:0] CmdBrInc   = 4'd10;
  localparam logic [3:0] CmdBrDec   = 4'd11;

  localparam logic [COORD_W-1:0] XMax  = COORD_W'(CANVAS_W - 1);
  localparam logic [COORD_W-1:0] YMax  = COORD_W'(CANVAS_H - 1);
  localparam logic [PX_W-1:0]    PxMax = PX_W'(PAL_COLS - 1);
  localparam logic [PY_W-1:0]    PyMax = PY_W'(PAL_ROWS - 1);
  localparam logic [BR_W-1:0]    BrMax = BR_W'(MAX_BRUSH);
  localparam logic [BR_W-1:0]    BrOne = BR_W'(1);

  typedef enum logic [0:0] {StIdle, StStamp} state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic [PX_W-1:0]    px_q, px_d;
  logic [PY_W-1:0]    py_q, py_d;
  logic [BR_W-1:0]    br_q, br_d;
  logic [COLOR_W-1:0] sel_q, sel_d;
  logic [COORD_W-1:0] ox_q, ox_d, oy_q, oy_d;
  logic [BR_W-1:0]    ew_q, ew_d, eh_q, eh_d;
  logic [BR_W-1:0]    dx_q, dx_d, dy_q, dy_d;
  logic [COLOR_W-1:0] col_q, col_d;

  function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] vmax);
    if (v == vmax) return (WRAP != 0) ? '0 : vmax;
    return v + COORD_W'(1);
  endfunction

  function automatic logic [COORD_W-1:0] coord_dec(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W-1:0] vmax);
    if (v == '0) return (WRAP != 0) ? vmax : '0;
    return v - COORD_W'(1);
  endfunction

  // Brush edge clipped to the room left between the origin and the far canvas edge.
  function automatic logic [BR_W-1:0] clip_edge(input logic [BR_W-1:0] br,
                                                input logic [COORD_W-1:0] o,
                                                input int unsigned lim);
    int room;
    room = int'(lim) - int'(o);
    if (int'(br) > room) return BR_W'(room);
    return br;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    px_d    = px_q;
    py_d    = py_q;
    br_d    = br_q;
    sel_d   = sel_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    ew_d    = ew_q;
    eh_d    = eh_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    col_d   = col_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_id)
            CmdUp: begin
              if (!mode_q)          cy_d = coord_dec(cy_q, YMax);
              else if (py_q != '0)  py_d = py_q - PY_W'(1);
            end
            CmdDown: begin
              if (!mode_q)          cy_d = coord_inc(cy_q, YMax);
              else if (py_q != PyMax) py_d = py_q + PY_W'(1);
            end
            CmdLeft: begin
              if (!mode_q)          cx_d = coord_dec(cx_q, XMax);
              else if (px_q != '0)  px_d = px_q - PX_W'(1);
            end
            CmdRight: begin
              if (!mode_q)          cx_d = coord_inc(cx_q, XMax);
              else if (px_q != PxMax) px_d = px_q + PX_W'(1);
            end
            CmdEnter, CmdPalSel: begin
              if (mode_q) begin
                sel_d  = COLOR_W'(int'(py_q) * int'(PAL_COLS) + int'(px_q));
                mode_d = 1'b0;
                cx_d   = sx_q;
                cy_d   = sy_q;
              end else if (cmd_id == CmdEnter) begin
                state_d = StStamp;
                ox_d    = cx_q;
                oy_d    = cy_q;
                col_d   = sel_q;
                ew_d    = clip_edge(br_q, cx_q, CANVAS_W);
                eh_d    = clip_edge(br_q, cy_q, CANVAS_H);
                dx_d    = '0;
                dy_d    = '0;
              end
            end
            CmdColor: begin
              if (!mode_q) begin
                sx_d   = cx_q;
                sy_d   = cy_q;
                mode_d = 1'b1;
                px_d   = '0;
                py_d   = '0;
              end
            end
            CmdPalMove: begin
              if (mode_q) begin
                px_d = (int'(x_in) > int'(PAL_COLS) - 1) ? PxMax : PX_W'(x_in);
                py_d = (int'(y_in) > int'(PAL_ROWS) - 1) ? PyMax : PY_W'(y_in);
              end
            end
            CmdReturn: begin
              if (mode_q) begin
                mode_d = 1'b0;
                cx_d   = sx_q;
                cy_d   = sy_q;
              end
            end
            CmdBrInc: if (br_q != BrMax) br_d = br_q + BrOne;
            CmdBrDec: if (br_q != BrOne) br_d = br_q - BrOne;
            default: ;
          endcase
        end
      end
      StStamp: begin
        if (wr_ready) begin
          if (dx_q == ew_q - BrOne) begin
            dx_d = '0;
            if (dy_q == eh_q - BrOne) state_d = StIdle;
            else                      dy_d = dy_q + BrOne;
          end else begin
            dx_d = dx_q + BrOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      mode_q  <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      br_q    <= BrOne;
      sel_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      ew_q    <= '0;
      eh_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      px_q    <= px_d;
      py_q    <= py_d;
      br_q    <= br_d;
      sel_q   <= sel_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      ew_q    <= ew_d;
      eh_q    <= eh_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    cmd_ready      = (state_q == StIdle);
    busy           = (state_q != StIdle);
    wr_valid       = (state_q == StStamp);
    wr_x           = ox_q + COORD_W'(dx_q);
    wr_y           = oy_q + COORD_W'(dy_q);
    wr_color       = col_q;
    mode           = mode_q;
    cursor_x       = cx_q;
    cursor_y       = cy_q;
    p_px           = px_q;
    p_py           = py_q;
    brush_size     = br_q;
    selected_color = sel_q;
  end

endmodule
